// File: rtl/check_move_multi_if.sv
// Request/result bundle between game control (master) and the collision checker (slave).
// Also supplies the move codes normally provided by defs.vh when that header is absent.
`ifndef MOVE_LEFT
`define MOVE_LEFT   3'd0
`endif
`ifndef MOVE_RIGHT
`define MOVE_RIGHT  3'd1
`endif
`ifndef MOVE_DOWN
`define MOVE_DOWN   3'd2
`endif
`ifndef MOVE_ROTATE
`define MOVE_ROTATE 3'd3
`endif
`ifndef MOVE_APPEAR
`define MOVE_APPEAR 3'd4
`endif

interface check_move_multi_if #(
  parameter int BLK_SIZE   = 4,
  parameter int FIELD_ROWS = 20,
  parameter int FIELD_COLS = 10,
  parameter int POS_W      = 6
);
  logic                                 req_valid_i;
  logic                                 req_ready_o;
  logic [2:0]                           req_move_i;
  logic [4*BLK_SIZE*BLK_SIZE-1:0]       b_data_i;
  logic [1:0]                           b_rotation_i;
  logic signed [POS_W-1:0]              b_x_i;
  logic signed [POS_W-1:0]              b_y_i;
  logic [FIELD_ROWS*FIELD_COLS-1:0]     field_i;
  logic                                 done_o;
  logic                                 can_move_o;
  logic signed [1:0]                    move_x_o;
  logic signed [1:0]                    move_y_o;
  logic [1:0]                           rot_o;

  modport master (
    output req_valid_i, req_move_i, b_data_i, b_rotation_i, b_x_i, b_y_i, field_i,
    input  req_ready_o, done_o, can_move_o, move_x_o, move_y_o, rot_o
  );

  modport slave (
    input  req_valid_i, req_move_i, b_data_i, b_rotation_i, b_x_i, b_y_i, field_i,
    output req_ready_o, done_o, can_move_o, move_x_o, move_y_o, rot_o
  );
endinterface

// File: rtl/check_move_multi.sv
// Piece-collision checker: scans the piece mask against the playfield LANES cells per cycle.
// Define CHECK_MOVE_WALL_KICK_EN to retry blocked rotations at dx = -1 then dx = +1.
module check_move_multi #(
  parameter int BLK_SIZE   = 4,
  parameter int FIELD_ROWS = 20,
  parameter int FIELD_COLS = 10,
  parameter int POS_W      = 6,
  parameter int LANES      = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  check_move_multi_if.slave bus
);
  localparam int CELLS   = BLK_SIZE * BLK_SIZE;
  localparam int GROUPS  = CELLS / LANES;
  localparam int IDX_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CELL_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int FIELD_W = $clog2(FIELD_ROWS * FIELD_COLS);

`ifdef CHECK_MOVE_WALL_KICK_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_KICK, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CELLS-1:0]        mask_q, mask_d;
  logic signed [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [1:0]       dx_q, dx_d, dy_q, dy_d;
  logic [1:0]              rot_chk_q, rot_chk_d, rot_base_q, rot_base_d;
  logic                    is_rot_q, is_rot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              kick_q, kick_d;
  logic                    can_move_q, can_move_d;
  logic signed [1:0]       move_x_q, move_x_d, move_y_q, move_y_d;
  logic [1:0]              rot_q, rot_d;
  logic                    hit;

  // Target coordinates are widened by one bit so edge offsets never wrap.
  function automatic logic cell_hit(input int k);
    logic signed [POS_W:0] r;
    logic signed [POS_W:0] c;
    int ri;
    int ci;
    r  = {y_q[POS_W-1], y_q} + (POS_W+1)'(k / BLK_SIZE) + {{(POS_W-1){dy_q[1]}}, dy_q};
    c  = {x_q[POS_W-1], x_q} + (POS_W+1)'(k % BLK_SIZE) + {{(POS_W-1){dx_q[1]}}, dx_q};
    ri = int'(r);
    ci = int'(c);
    cell_hit = 1'b0;
    if (mask_q[CELL_W'(k)]) begin
      if (ri < 0 || ci < 0 || ri >= FIELD_ROWS || ci >= FIELD_COLS)
        cell_hit = 1'b1;
      else
        cell_hit = bus.field_i[FIELD_W'(ri * FIELD_COLS + ci)];
    end
  endfunction

  always_comb begin
    hit = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (cell_hit(int'(idx_q) * LANES + l)) hit = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    rot_chk_d  = rot_chk_q;
    rot_base_d = rot_base_q;
    is_rot_d   = is_rot_q;
    idx_d      = idx_q;
    kick_d     = kick_q;
    can_move_d = can_move_q;
    move_x_d   = move_x_q;
    move_y_d   = move_y_q;
    rot_d      = rot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          is_rot_d   = (bus.req_move_i == `MOVE_ROTATE);
          rot_base_d = bus.b_rotation_i;
          rot_chk_d  = is_rot_d ? bus.b_rotation_i + 2'd1 : bus.b_rotation_i;
          for (int rr = 0; rr < 4; rr++)
            if (rot_chk_d == 2'(rr)) mask_d = bus.b_data_i[rr*CELLS +: CELLS];
          x_d  = bus.b_x_i;
          y_d  = bus.b_y_i;
          dx_d = 2'b00;
          dy_d = 2'b00;
          case (bus.req_move_i)
            `MOVE_LEFT:  dx_d = 2'b11;
            `MOVE_RIGHT: dx_d = 2'b01;
            `MOVE_DOWN:  dy_d = 2'b01;
            default:     ;
          endcase
          idx_d   = '0;
          kick_d  = 2'd0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hit) begin
          if (KICK_EN && is_rot_q && kick_q != 2'd2) begin
            state_d = ST_KICK;
          end else begin
            state_d    = ST_DONE;
            can_move_d = 1'b0;
            move_x_d   = 2'b00;
            move_y_d   = 2'b00;
            rot_d      = rot_base_q;
          end
        end else if (idx_q == IDX_W'(GROUPS - 1)) begin
          state_d    = ST_DONE;
          can_move_d = 1'b1;
          move_x_d   = dx_q;
          move_y_d   = dy_q;
          rot_d      = rot_chk_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_KICK: begin
        dx_d    = (kick_q == 2'd0) ? 2'b11 : 2'b01;
        kick_d  = kick_q + 2'd1;
        idx_d   = '0;
        state_d = ST_CHECK;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      rot_chk_q  <= '0;
      rot_base_q <= '0;
      is_rot_q   <= 1'b0;
      idx_q      <= '0;
      kick_q     <= '0;
      can_move_q <= 1'b0;
      move_x_q   <= '0;
      move_y_q   <= '0;
      rot_q      <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      rot_chk_q  <= rot_chk_d;
      rot_base_q <= rot_base_d;
      is_rot_q   <= is_rot_d;
      idx_q      <= idx_d;
      kick_q     <= kick_d;
      can_move_q <= can_move_d;
      move_x_q   <= move_x_d;
      move_y_q   <= move_y_d;
      rot_q      <= rot_d;
    end
  end

  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.can_move_o  = can_move_q;
  assign bus.move_x_o    = move_x_q;
  assign bus.move_y_o    = move_y_q;
  assign bus.rot_o       = rot_q;
endmodule
